control: RTL and testbench

- Multi-cycle FSM controller for the tiny8 core; sits directly upstream of the datapath and drives all of its register loads, ALU op and mux selects.
- Sequences fetch / decode / execute per instruction from the decoded opcode.
- Owns the memory read/write strobes and waits on a memory response handshake.

---
 rtl/control.sv | 168 ++++++++++++++++
 tb/tb_control.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control.sv
// tiny8 multi-cycle controller: fetch/decode/execute sequencing,
// memory strobes with response handshake and optional wait timeout.
package tiny8_pkg;

  typedef enum logic [3:0] {
    op_addi = 4'h0,
    op_inc  = 4'h1,
    op_acc  = 4'h2,
    op_ld   = 4'h3,
    op_st   = 4'h4,
    op_br   = 4'h5,
    op_halt = 4'h6
  } tiny8_opcode;

  typedef enum logic [2:0] {
    alu_add  = 3'd0,
    alu_sub  = 3'd1,
    alu_and  = 3'd2,
    alu_or   = 3'd3,
    alu_xor  = 3'd4,
    alu_pass = 3'd5
  } tiny8_aluop;

endpackage

module control
  import tiny8_pkg::*;
#(
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int unsigned WAIT_LIMIT      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  tiny8_opcode opcode,
  input  logic        mem_resp,
  output logic        load_pc,
  output logic        load_ir,
  output logic        load_acc,
  output logic        load_rs,
  output logic        load_rd,
  output tiny8_aluop  aluop,
  output logic        pcmux_sel,
  output logic [1:0]  addrmux_sel,
  output logic        alumux1_sel,
  output logic        alumux2_sel,
  output logic        regfilemux_sel,
  output logic        mem_read,
  output logic        mem_write,
  output logic        halted
);

  localparam int unsigned CW =
    (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC,
    S_LD, S_ST, S_BR, S_HALT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] wait_cnt, wait_cnt_n;
  logic          strobe, resp, timeout;

  assign strobe = state inside {S_FETCH, S_LD, S_ST};
  // a response coinciding with rst must not commit any load
  assign resp = strobe && mem_resp && !rst;
  // fires on the WAIT_LIMIT-th consecutive unanswered strobe cycle
  assign timeout = (WAIT_LIMIT != 0) && strobe &&
                   !mem_resp && (wait_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_FETCH, S_LD, S_ST: begin
        if (mem_resp)
          state_n = (state == S_FETCH) ? S_DECODE : S_FETCH;
        else if (timeout)
          state_n = S_HALT;
      end
      S_DECODE: begin
        unique case (1'b1)
          (opcode inside {op_addi, op_inc, op_acc}):
            state_n = S_EXEC;
          (opcode == op_ld):   state_n = S_LD;
          (opcode == op_st):   state_n = S_ST;
          (opcode == op_br):   state_n = S_BR;
          (opcode == op_halt): state_n = S_HALT;
          default:
            state_n = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_EXEC, S_BR: state_n = S_FETCH;
      S_HALT:       state_n = S_HALT;
      default:      state_n = S_FETCH;
    endcase
  end

  always_comb begin
    if (!strobe || mem_resp || state_n != state)
      wait_cnt_n = '0;
    else
      wait_cnt_n = wait_cnt + CW'(1);
  end

  always_comb begin
    load_pc        = 1'b0;
    load_ir        = 1'b0;
    load_acc       = 1'b0;
    load_rs        = 1'b0;
    load_rd        = 1'b0;
    aluop          = alu_add;
    pcmux_sel      = 1'b0;
    addrmux_sel    = 2'd0;
    alumux1_sel    = 1'b0;
    alumux2_sel    = 1'b0;
    regfilemux_sel = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    halted         = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        load_ir  = resp;
        load_pc  = resp;
      end
      S_EXEC: begin
        unique case (1'b1)
          (opcode == op_addi): begin
            alumux1_sel = 1'b1;
            alumux2_sel = 1'b1;
            load_rd     = 1'b1;
          end
          (opcode == op_inc): load_rs  = 1'b1;
          (opcode == op_acc): load_acc = 1'b1;
          default: ;
        endcase
      end
      S_LD: begin
        mem_read       = 1'b1;
        addrmux_sel    = 2'd1;
        regfilemux_sel = 1'b1;
        load_rd        = resp;
      end
      S_ST: begin
        mem_write   = 1'b1;
        addrmux_sel = 2'd2;
      end
      S_BR: begin
        load_pc   = 1'b1;
        pcmux_sel = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control.sv
// Scoreboard bench for control: stimulus queues expected control
// vectors per cycle; a monitor pops and compares on the falling edge.
module tb_control;
  import tiny8_pkg::*;

  typedef struct packed {
    logic       load_pc;
    logic       load_ir;
    logic       load_acc;
    logic       load_rs;
    logic       load_rd;
    logic [2:0] aluop;
    logic       pcmux_sel;
    logic [1:0] addrmux_sel;
    logic       alumux1_sel;
    logic       alumux2_sel;
    logic       regfilemux_sel;
    logic       mem_read;
    logic       mem_write;
    logic       halted;
  } ctl_t;

  typedef struct {
    bit    w;
    ctl_t  e;
    string n;
  } rec_t;

  logic clk;
  logic rst_m, rst_w, resp_m, resp_w;
  tiny8_opcode op_m, op_w;

  logic m_lpc, m_lir, m_lacc, m_lrs, m_lrd;
  logic w_lpc, w_lir, w_lacc, w_lrs, w_lrd;
  tiny8_aluop m_alu, w_alu;
  logic m_pcm, m_a1, m_a2, m_rf, m_mr, m_mw, m_h;
  logic w_pcm, w_a1, w_a2, w_rf, w_mr, w_mw, w_h;
  logic [1:0] m_addr, w_addr;
  ctl_t out_m, out_w;

  rec_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  control dut_m (
    .clk(clk), .rst(rst_m), .opcode(op_m),
    .mem_resp(resp_m),
    .load_pc(m_lpc), .load_ir(m_lir),
    .load_acc(m_lacc), .load_rs(m_lrs),
    .load_rd(m_lrd), .aluop(m_alu),
    .pcmux_sel(m_pcm), .addrmux_sel(m_addr),
    .alumux1_sel(m_a1), .alumux2_sel(m_a2),
    .regfilemux_sel(m_rf), .mem_read(m_mr),
    .mem_write(m_mw), .halted(m_h)
  );

  control #(
    .HALT_ON_ILLEGAL(1'b0),
    .WAIT_LIMIT(3)
  ) dut_w (
    .clk(clk), .rst(rst_w), .opcode(op_w),
    .mem_resp(resp_w),
    .load_pc(w_lpc), .load_ir(w_lir),
    .load_acc(w_lacc), .load_rs(w_lrs),
    .load_rd(w_lrd), .aluop(w_alu),
    .pcmux_sel(w_pcm), .addrmux_sel(w_addr),
    .alumux1_sel(w_a1), .alumux2_sel(w_a2),
    .regfilemux_sel(w_rf), .mem_read(w_mr),
    .mem_write(w_mw), .halted(w_h)
  );

  assign out_m = {m_lpc, m_lir, m_lacc, m_lrs, m_lrd,
                  m_alu, m_pcm, m_addr, m_a1, m_a2,
                  m_rf, m_mr, m_mw, m_h};
  assign out_w = {w_lpc, w_lir, w_lacc, w_lrs, w_lrd,
                  w_alu, w_pcm, w_addr, w_a1, w_a2,
                  w_rf, w_mr, w_mw, w_h};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t idle();
    ctl_t e = '0;
    return e;
  endfunction

  function automatic ctl_t fetch(input bit r);
    ctl_t e = '0;
    e.mem_read = 1'b1;
    e.load_ir  = r;
    e.load_pc  = r;
    return e;
  endfunction

  function automatic ctl_t ld(input bit r);
    ctl_t e = '0;
    e.mem_read       = 1'b1;
    e.addrmux_sel    = 2'd1;
    e.regfilemux_sel = 1'b1;
    e.load_rd        = r;
    return e;
  endfunction

  function automatic ctl_t st();
    ctl_t e = '0;
    e.mem_write   = 1'b1;
    e.addrmux_sel = 2'd2;
    return e;
  endfunction

  function automatic ctl_t br();
    ctl_t e = '0;
    e.load_pc   = 1'b1;
    e.pcmux_sel = 1'b1;
    return e;
  endfunction

  function automatic ctl_t hlt();
    ctl_t e = '0;
    e.halted = 1'b1;
    return e;
  endfunction

  function automatic ctl_t ex_addi();
    ctl_t e = '0;
    e.alumux1_sel = 1'b1;
    e.alumux2_sel = 1'b1;
    e.load_rd     = 1'b1;
    return e;
  endfunction

  function automatic ctl_t ex_inc();
    ctl_t e = '0;
    e.load_rs = 1'b1;
    return e;
  endfunction

  function automatic ctl_t ex_acc();
    ctl_t e = '0;
    e.load_acc = 1'b1;
    return e;
  endfunction

  task automatic cyc(input ctl_t e, input string n,
                     input bit w);
    rec_t r;
    r.w = w;
    r.e = e;
    r.n = n;
    sbq.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic alu_instr(input tiny8_opcode op,
                           input ctl_t ex,
                           input string n);
    op_m   = op;
    resp_m = 1'b1;
    cyc(fetch(1), {n, "_fetch"}, 0);
    cyc(idle(), {n, "_dec_resp_ignored"}, 0);
    resp_m = 1'b0;
    cyc(ex, {n, "_exec"}, 0);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      rec_t r;
      ctl_t act;
      r   = sbq.pop_front();
      act = r.w ? out_w : out_m;
      n_tests++;
      if (act !== r.e) begin
        n_fail++;
        $display("FAIL %s: got %h required %h",
                 r.n, act, r.e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_m  = 1'b1;
    rst_w  = 1'b1;
    resp_m = 1'b0;
    resp_w = 1'b0;
    op_m   = op_addi;
    op_w   = op_addi;
    @(posedge clk);
    #1;
    cyc(fetch(0), "reset_state", 0);

    rst_m  = 1'b0;
    op_m   = op_addi;
    resp_m = 1'b1;
    cyc(fetch(1), "addi_fetch", 0);
    resp_m = 1'b0;
    cyc(idle(), "addi_dec", 0);
    cyc(ex_addi(), "addi_exec", 0);

    alu_instr(op_inc, ex_inc(), "inc");
    alu_instr(op_acc, ex_acc(), "acc");

    op_m   = op_ld;
    resp_m = 1'b1;
    cyc(fetch(1), "ld_fetch", 0);
    resp_m = 1'b0;
    cyc(idle(), "ld_dec", 0);
    repeat (4) cyc(ld(0), "ld_wait", 0);
    resp_m = 1'b1;
    cyc(ld(1), "ld_resp", 0);
    resp_m = 1'b0;
    cyc(fetch(0), "ld_back", 0);

    op_m   = op_st;
    resp_m = 1'b1;
    cyc(fetch(1), "st_fetch", 0);
    resp_m = 1'b0;
    cyc(idle(), "st_dec", 0);
    repeat (2) cyc(st(), "st_wait", 0);
    resp_m = 1'b1;
    cyc(st(), "st_resp", 0);

    op_m = op_br;
    cyc(fetch(1), "br_fetch", 0);
    resp_m = 1'b0;
    cyc(idle(), "br_dec", 0);
    cyc(br(), "br_exec", 0);
    cyc(fetch(0), "br_one_cycle", 0);

    op_m   = op_halt;
    resp_m = 1'b1;
    cyc(fetch(1), "halt_fetch", 0);
    resp_m = 1'b0;
    cyc(idle(), "halt_dec", 0);
    cyc(hlt(), "halt_enter", 0);
    resp_m = 1'b1;
    op_m   = op_ld;
    cyc(hlt(), "halt_resp_ignored", 0);
    resp_m = 1'b0;
    op_m   = op_br;
    cyc(hlt(), "halt_op_change", 0);
    rst_m = 1'b1;
    cyc(hlt(), "halt_rst_cycle", 0);
    rst_m = 1'b0;
    cyc(fetch(0), "halt_rst_exit", 0);

    op_m   = tiny8_opcode'(4'hF);
    resp_m = 1'b1;
    cyc(fetch(1), "ill_fetch", 0);
    resp_m = 1'b0;
    cyc(idle(), "ill_dec", 0);
    cyc(hlt(), "ill_halt", 0);
    rst_m = 1'b1;
    cyc(hlt(), "ill_rst_cycle", 0);
    rst_m = 1'b0;

    op_m   = op_ld;
    resp_m = 1'b1;
    cyc(fetch(1), "ldrst_fetch", 0);
    resp_m = 1'b0;
    cyc(idle(), "ldrst_dec", 0);
    cyc(ld(0), "ldrst_wait", 0);
    rst_m  = 1'b1;
    resp_m = 1'b1;
    cyc(ld(0), "ldrst_rst_beats_resp", 0);
    rst_m  = 1'b0;
    resp_m = 1'b0;
    cyc(fetch(0), "ldrst_back_fetch", 0);

    cyc(fetch(0), "w_reset_state", 1);
    rst_w  = 1'b0;
    op_w   = tiny8_opcode'(4'hF);
    resp_w = 1'b1;
    cyc(fetch(1), "w_ill_fetch", 1);
    resp_w = 1'b0;
    cyc(idle(), "w_ill_dec", 1);
    cyc(fetch(0), "w_ill_nop_wait0", 1);
    cyc(fetch(0), "w_wait1", 1);
    cyc(fetch(0), "w_wait2", 1);
    cyc(hlt(), "w_timeout_halt", 1);
    resp_w = 1'b1;
    cyc(hlt(), "w_halt_resp_ignored", 1);
    resp_w = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, required 0",
               sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
